// File: rtl/fadd_sched_pkg.sv
// rtl/fadd_sched_pkg.sv - shared constants, FSM state type and tag width helper (FADD_SCHED_RR_EN selects arbitration)
package fadd_sched_pkg;

    localparam int FP_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Width needed to hold a requester index; never narrower than one bit.
    function automatic int tag_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fadd_rr_arb.sv
// rtl/fadd_rr_arb.sv - requester arbiter, round-robin under FADD_SCHED_RR_EN, fixed priority otherwise
module fadd_rr_arb #(
    parameter int NREQ = 4,
    parameter int TW   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    input  logic            accept,
    output logic [TW-1:0]   grant,
    output logic            grant_any
);

`ifdef FADD_SCHED_RR_EN
    logic [TW-1:0] ptr;

    // Remember the last winner so the search resumes just after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= TW'(NREQ - 1);
        end else if (accept) begin
            ptr <= grant;
        end
    end

    // Walk from ptr+1 around the ring; the nearest pending requester wins.
    always_comb begin
        grant     = '0;
        grant_any = |req_valid;
        for (int i = NREQ; i >= 1; i--) begin
            if (req_valid[(int'(ptr) + i) % NREQ]) begin
                grant = TW'((int'(ptr) + i) % NREQ);
            end
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, accept};

    // Lowest pending index wins.
    always_comb begin
        grant     = '0;
        grant_any = |req_valid;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant = TW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/fadd_scheduler.sv
// rtl/fadd_scheduler.sv - shares one FP adder among NREQ requesters (FADD_SCHED_RR_EN enables round-robin)
module fadd_scheduler
    import fadd_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*FP_W-1:0] req_a,
    input  logic [NREQ*FP_W-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [FP_W-1:0]      resp_data,
    output logic                 resp_flag,
    output logic                 add_en,
    output logic [FP_W-1:0]      add_a,
    output logic [FP_W-1:0]      add_b,
    input  logic [FP_W-1:0]      add_out,
    input  logic                 add_flag,
    output logic                 busy
);

    localparam int TW = tag_w(NREQ);
    localparam int CW = $clog2(LAT + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tag;
    logic [TW-1:0] grant;
    logic          grant_any;
    logic          accept;

    assign accept = (state == IDLE) && grant_any;

    fadd_rr_arb #(
        .NREQ (NREQ),
        .TW   (TW)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .accept    (accept),
        .grant     (grant),
        .grant_any (grant_any)
    );

    // Accept strobe is shown in the IDLE cycle itself so the requester can drop on the same edge the operands are latched.
    always_comb begin
        req_ready = '0;
        if (rst_n && accept) begin
            req_ready = NREQ'(1) << grant;
        end
    end

    // Operation sequencer: accept, hold the adder for LAT cycles, then present the result until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            tag        <= '0;
            add_en     <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_flag  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        add_a  <= req_a[int'(grant)*FP_W +: FP_W];
                        add_b  <= req_b[int'(grant)*FP_W +: FP_W];
                        tag    <= grant;
                        cnt    <= '0;
                        add_en <= 1'b1;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(LAT - 1)) begin
                        add_en     <= 1'b0;
                        resp_data  <= add_out;
                        resp_flag  <= add_flag;
                        resp_valid <= NREQ'(1) << tag;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready[tag]) begin
                        resp_valid <= '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fadd_scheduler.sv
// tb/tb_fadd_scheduler.sv - directed bench for fadd_scheduler with LAT=1 and LAT=3 instances
module tb_fadd_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural adder: known vectors from hand arithmetic, otherwise an arbitrary but operand-unique pattern.
    function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h41B26666_BF000000: return 32'h41AE6666;
            64'h417CCCCD_3FA66666: return 32'h4188CCCD;
            64'hBF800000_40000000: return 32'h3F800000;
            default:               return a ^ {b[15:0], b[31:16]};
        endcase
    endfunction

    // Flag reported by the model adder: operands of opposite sign.
    function automatic logic model_flag(input logic [31:0] a, input logic [31:0] b);
        return a[31] ^ b[31];
    endfunction

    // LAT=1 instance
    logic [3:0]   s1_req_valid, s1_req_ready, s1_resp_valid, s1_resp_ready;
    logic [127:0] s1_req_a, s1_req_b;
    logic [31:0]  s1_resp_data, s1_add_a, s1_add_b, s1_add_out;
    logic         s1_resp_flag, s1_add_en, s1_add_flag, s1_busy;
    int           s1_run = 0;
    int           s1_en_total = 0;

    // LAT=3 instance
    logic [3:0]   s3_req_valid, s3_req_ready, s3_resp_valid, s3_resp_ready;
    logic [127:0] s3_req_a, s3_req_b;
    logic [31:0]  s3_resp_data, s3_add_a, s3_add_b, s3_add_out;
    logic         s3_resp_flag, s3_add_en, s3_add_flag, s3_busy;
    int           s3_run = 0;
    int           s3_en_total = 0;

    fadd_scheduler #(.NREQ(4), .LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s1_req_valid), .req_a(s1_req_a), .req_b(s1_req_b), .req_ready(s1_req_ready),
        .resp_valid(s1_resp_valid), .resp_ready(s1_resp_ready), .resp_data(s1_resp_data), .resp_flag(s1_resp_flag),
        .add_en(s1_add_en), .add_a(s1_add_a), .add_b(s1_add_b), .add_out(s1_add_out), .add_flag(s1_add_flag),
        .busy(s1_busy)
    );

    fadd_scheduler #(.NREQ(4), .LAT(3)) u3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s3_req_valid), .req_a(s3_req_a), .req_b(s3_req_b), .req_ready(s3_req_ready),
        .resp_valid(s3_resp_valid), .resp_ready(s3_resp_ready), .resp_data(s3_resp_data), .resp_flag(s3_resp_flag),
        .add_en(s3_add_en), .add_a(s3_add_a), .add_b(s3_add_b), .add_out(s3_add_out), .add_flag(s3_add_flag),
        .busy(s3_busy)
    );

    // Adder output is only meaningful on the LAT-th consecutive enabled cycle; garbage otherwise.
    always @(posedge clk) begin
        s1_run <= s1_add_en ? s1_run + 1 : 0;
        s3_run <= s3_add_en ? s3_run + 1 : 0;
        if (s1_add_en) s1_en_total <= s1_en_total + 1;
        if (s3_add_en) s3_en_total <= s3_en_total + 1;
    end

    assign s1_add_out  = (s1_add_en && s1_run >= 0) ? model_sum(s1_add_a, s1_add_b) : 32'hBAD0BAD0;
    assign s1_add_flag = (s1_add_en && s1_run >= 0) ? model_flag(s1_add_a, s1_add_b) : 1'b0;
    assign s3_add_out  = (s3_add_en && s3_run >= 2) ? model_sum(s3_add_a, s3_add_b) : 32'hBAD0BAD0;
    assign s3_add_flag = (s3_add_en && s3_run >= 2) ? model_flag(s3_add_a, s3_add_b) : 1'b0;

    task automatic pulse_reset;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        s1_req_valid = 4'hF; s1_req_a = '0; s1_req_b = '0; s1_resp_ready = '0;
        s3_req_valid = 4'h0; s3_req_a = '0; s3_req_b = '0; s3_resp_ready = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (s1_req_ready !== 4'h0) begin
            n_fail++; $display("FAIL reset_req_ready: got %h expected 0", s1_req_ready);
        end
        n_checks++;
        if ({s1_resp_valid, s1_resp_data, s1_resp_flag, s1_add_en, s1_add_a, s1_add_b, s1_busy} !== '0) begin
            n_fail++; $display("FAIL reset_outputs_lat1: got rv=%h rd=%h rf=%b en=%b a=%h b=%h busy=%b expected all 0",
                               s1_resp_valid, s1_resp_data, s1_resp_flag, s1_add_en, s1_add_a, s1_add_b, s1_busy);
        end
        n_checks++;
        if ({s3_req_ready, s3_resp_valid, s3_resp_data, s3_resp_flag, s3_add_en, s3_add_a, s3_add_b, s3_busy} !== '0) begin
            n_fail++; $display("FAIL reset_outputs_lat3: got rr=%h rv=%h rd=%h busy=%b expected all 0",
                               s3_req_ready, s3_resp_valid, s3_resp_data, s3_busy);
        end
        s1_req_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        int en0;
        @(negedge clk);
        en0 = s1_en_total;
        s1_req_valid = 4'b0100;
        s1_req_a[2*32 +: 32] = 32'h41B26666;
        s1_req_b[2*32 +: 32] = 32'hBF000000;
        s1_resp_ready = 4'b0100;
        #1;
        n_checks++;
        if (s1_req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL single_accept: got %b expected 0100", s1_req_ready);
        end
        @(negedge clk);
        s1_req_valid = 4'b0000;
        #1;
        n_checks++;
        if ({s1_add_en, s1_busy, s1_req_ready} !== {1'b1, 1'b1, 4'b0000}) begin
            n_fail++; $display("FAIL single_exec: got en=%b busy=%b rr=%b expected en=1 busy=1 rr=0000", s1_add_en, s1_busy, s1_req_ready);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({s1_resp_valid, s1_resp_data, s1_add_en} !== {4'b0100, 32'h41AE6666, 1'b0}) begin
            n_fail++; $display("FAIL single_resp: got rv=%b rd=%h en=%b expected rv=0100 rd=41ae6666 en=0", s1_resp_valid, s1_resp_data, s1_add_en);
        end
        n_checks++;
        if (s1_resp_flag !== 1'b1) begin
            n_fail++; $display("FAIL single_flag: got %b expected 1", s1_resp_flag);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({s1_resp_valid, s1_busy} !== 5'b0) begin
            n_fail++; $display("FAIL single_release: got rv=%b busy=%b expected 0000 0", s1_resp_valid, s1_busy);
        end
        n_checks++;
        if (s1_en_total - en0 !== 1) begin
            n_fail++; $display("FAIL single_en_cycles: got %0d expected 1", s1_en_total - en0);
        end
    endtask

    task automatic test_lat3_stall;
        int en0;
        @(negedge clk);
        en0 = s3_en_total;
        s3_req_valid = 4'b0001;
        s3_req_a[31:0] = 32'h417CCCCD;
        s3_req_b[31:0] = 32'h3FA66666;
        s3_resp_ready = 4'b0000;
        #1;
        n_checks++;
        if (s3_req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL lat3_accept: got %b expected 0001", s3_req_ready);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            s3_req_valid = 4'b0000;
            #1;
            n_checks++;
            if ({s3_add_en, s3_resp_valid} !== {1'b1, 4'b0000}) begin
                n_fail++; $display("FAIL lat3_exec_%0d: got en=%b rv=%b expected en=1 rv=0000", k, s3_add_en, s3_resp_valid);
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({s3_resp_valid, s3_resp_data, s3_resp_flag, s3_busy, s3_add_en} !== {4'b0001, 32'h4188CCCD, 1'b0, 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL lat3_hold_%0d: got rv=%b rd=%h rf=%b busy=%b en=%b expected 0001 4188cccd 0 1 0",
                                   k, s3_resp_valid, s3_resp_data, s3_resp_flag, s3_busy, s3_add_en);
            end
        end
        s3_resp_ready = 4'b0001;
        @(negedge clk);
        s3_resp_ready = 4'b0000;
        #1;
        n_checks++;
        if ({s3_resp_valid, s3_busy} !== 5'b0) begin
            n_fail++; $display("FAIL lat3_release: got rv=%b busy=%b expected 0000 0", s3_resp_valid, s3_busy);
        end
        n_checks++;
        if (s3_en_total - en0 !== 3) begin
            n_fail++; $display("FAIL lat3_en_cycles: got %0d expected 3", s3_en_total - en0);
        end
    endtask

    task automatic test_arbitration;
        int grants[5];
        int exp_g[5];
        int n = 0;
        int g;
        logic [31:0] exp_d;
`ifdef FADD_SCHED_RR_EN
        exp_g = '{0, 1, 2, 3, 0};
`else
        exp_g = '{0, 0, 0, 0, 0};
`endif
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            s1_req_a[i*32 +: 32] = 32'h3F800000 + 32'(i);
            s1_req_b[i*32 +: 32] = 32'h40000000 + 32'(i << 8);
        end
        s1_req_valid  = 4'b1111;
        s1_resp_ready = 4'b1111;
        for (int c = 0; c < 80 && n < 5; c++) begin
            #1;
            if (s1_req_ready !== 4'b0000) begin
                g = 0;
                for (int k = 0; k < 4; k++) if (s1_req_ready[k]) g = k;
                n_checks++;
                if (!$onehot(s1_req_ready)) begin
                    n_fail++; $display("FAIL arb_onehot: got %b expected one-hot", s1_req_ready);
                end
                grants[n] = g;
                n++;
            end
            if (s1_resp_valid !== 4'b0000) begin
                g = 0;
                for (int k = 0; k < 4; k++) if (s1_resp_valid[k]) g = k;
                exp_d = model_sum(s1_req_a[g*32 +: 32], s1_req_b[g*32 +: 32]);
                n_checks++;
                if (s1_resp_data !== exp_d) begin
                    n_fail++; $display("FAIL arb_resp_data: req %0d got %h expected %h", g, s1_resp_data, exp_d);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (n != 5) begin
            n_fail++; $display("FAIL arb_timeout: got %0d grants expected 5", n);
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (grants[k] != exp_g[k]) begin
                    n_fail++; $display("FAIL arb_grant_%0d: got %0d expected %0d", k, grants[k], exp_g[k]);
                end
            end
        end
        s1_req_valid = 4'b0000;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int t1, t2, tr;
        logic [3:0] g2;
        pulse_reset();
        t2 = -1; tr = -1; g2 = '0;
        s1_req_a[1*32 +: 32] = 32'h40400000;
        s1_req_b[1*32 +: 32] = 32'h40800000;
        s1_req_a[3*32 +: 32] = 32'hBF800000;
        s1_req_b[3*32 +: 32] = 32'h40000000;
        s1_resp_ready = 4'b1111;
        s1_req_valid  = 4'b1010;
        #1;
        t1 = cyc;
        n_checks++;
        if (s1_req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL b2b_first_accept: got %b expected 0010", s1_req_ready);
        end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) s1_req_valid = 4'b1000;
            #1;
            if (s1_resp_valid === 4'b0010 && tr < 0) tr = cyc;
            if (s1_req_ready !== 4'b0000) begin
                t2 = cyc;
                g2 = s1_req_ready;
                break;
            end
        end
        n_checks++;
        if (t2 - t1 != 3 || g2 !== 4'b1000) begin
            n_fail++; $display("FAIL b2b_spacing: got gap=%0d ready=%b expected gap=3 ready=1000", t2 - t1, g2);
        end
        n_checks++;
        if (tr - t1 != 2) begin
            n_fail++; $display("FAIL b2b_resp_rise: got %0d expected 2", tr - t1);
        end
        @(negedge clk);
        s1_req_valid = 4'b0000;
        @(negedge clk);
        #1;
        n_checks++;
        if ({s1_resp_valid, s1_resp_data} !== {4'b1000, 32'h3F800000}) begin
            n_fail++; $display("FAIL b2b_second_resp: got rv=%b rd=%h expected 1000 3f800000", s1_resp_valid, s1_resp_data);
        end
        n_checks++;
        if (s1_resp_flag !== model_flag(32'hBF800000, 32'h40000000)) begin
            n_fail++; $display("FAIL b2b_flag: got %b expected %b", s1_resp_flag, model_flag(32'hBF800000, 32'h40000000));
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mid_reset;
        logic seen_resp;
        seen_resp = 1'b0;
        @(negedge clk);
        s3_req_valid = 4'b0010;
        s3_req_a[1*32 +: 32] = 32'h12345678;
        s3_req_b[1*32 +: 32] = 32'h9ABCDEF0;
        s3_resp_ready = 4'b1111;
        @(negedge clk);
        s3_req_valid = 4'b0000;
        #1;
        n_checks++;
        if ({s3_add_en, s3_busy} !== 2'b11) begin
            n_fail++; $display("FAIL midrst_exec: got en=%b busy=%b expected 1 1", s3_add_en, s3_busy);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({s3_add_en, s3_busy, s3_add_a, s3_resp_valid} !== '0) begin
            n_fail++; $display("FAIL midrst_abort: got en=%b busy=%b a=%h rv=%b expected all 0", s3_add_en, s3_busy, s3_add_a, s3_resp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (s3_resp_valid !== 4'b0000 || s3_busy !== 1'b0) seen_resp = 1'b1;
        end
        n_checks++;
        if (seen_resp !== 1'b0) begin
            n_fail++; $display("FAIL midrst_no_resp: got activity=%b expected 0", seen_resp);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_lat3_stall();
        test_arbitration();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
